// File: rtl/mem_request_scheduler.sv
// Ring of outstanding trace memory requests, issued to a single memory port one
// at a time and retired in allocation order.
module mem_request_scheduler #(
   parameter int TRACKER_SLOTS   = 4,
   parameter int TRACE_ENTRIES   = 8192,
   parameter int DATA_ADDR_WIDTH = 32,
   localparam int IDX_W = $clog2(TRACE_ENTRIES),
   localparam int OCC_W = $clog2(TRACKER_SLOTS + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       alloc_valid,
   input  logic [DATA_ADDR_WIDTH-1:0] alloc_addr,
   input  logic [IDX_W-1:0]           alloc_index,
   output logic                       alloc_ready,
   output logic                       mem_req,
   output logic [DATA_ADDR_WIDTH-1:0] mem_addr,
   input  logic                       mem_gnt,
   input  logic                       mem_rvalid,
   output logic                       retire_valid,
   output logic [IDX_W-1:0]           retire_index,
   output logic [OCC_W-1:0]           occupancy
);

   localparam int PTR_W = $clog2(TRACKER_SLOTS);

   typedef struct packed {
      logic                       occupied;
      logic [DATA_ADDR_WIDTH-1:0] mem_addr;
      logic                       processing;
      logic [IDX_W-1:0]           trace_index;
   } cache_tracker_t;

   typedef enum logic [1:0] {
      MAKE_REQUEST,
      WAIT_FOR_PROCESSING,
      REQUEST_RETIRED
   } mem_action_e;

   cache_tracker_t   slots [TRACKER_SLOTS];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [OCC_W-1:0] occ_q;
   mem_action_e      state;
   logic             alloc_fire;
   logic             grant_fire;

   // All outputs decode registered state only, so a same-cycle retire never
   // reopens a full tracker and mem_req/mem_addr hold steady until granted.
   assign alloc_ready  = (occ_q != OCC_W'(TRACKER_SLOTS));
   assign alloc_fire   = alloc_valid && alloc_ready;
   assign mem_req      = (state == MAKE_REQUEST) && slots[head].occupied && !slots[head].processing;
   assign mem_addr     = mem_req ? slots[head].mem_addr : '0;
   assign grant_fire   = mem_req && mem_gnt;
   assign retire_valid = (state == REQUEST_RETIRED);
   assign retire_index = retire_valid ? slots[head].trace_index : '0;
   assign occupancy    = occ_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the slot array is reset explicitly because occupied/processing
         // are control state; a stale occupied bit would issue a phantom request.
         for (int i = 0; i < TRACKER_SLOTS; i++) slots[i] <= '0;
         head  <= '0;
         tail  <= '0;
         occ_q <= '0;
         state <= MAKE_REQUEST;
      end else begin
         // tail can only equal head here when the ring is empty, so this write
         // never collides with the grant/retire update of slots[head].
         if (alloc_fire) begin
            slots[tail] <= '{occupied: 1'b1, mem_addr: alloc_addr,
                             processing: 1'b0, trace_index: alloc_index};
            tail        <= tail + PTR_W'(1);
         end

         case (state)
            MAKE_REQUEST: begin
               if (grant_fire) begin
                  slots[head].processing <= 1'b1;
                  state                  <= WAIT_FOR_PROCESSING;
               end
            end
            WAIT_FOR_PROCESSING: begin
               if (mem_rvalid) state <= REQUEST_RETIRED;
            end
            REQUEST_RETIRED: begin
               slots[head].occupied   <= 1'b0;
               slots[head].processing <= 1'b0;
               head                   <= head + PTR_W'(1);
               state                  <= MAKE_REQUEST;
            end
            default: state <= MAKE_REQUEST;
         endcase

         case ({alloc_fire, retire_valid})
            2'b10:   occ_q <= occ_q + OCC_W'(1);
            2'b01:   occ_q <= occ_q - OCC_W'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_request_scheduler.sv
// Bench for mem_request_scheduler: a behavioural model plus a queue of accepted
// requests, compared against the DUT once per cycle.
module tb_mem_request_scheduler;

   localparam int SLOTS = 4;
   localparam int IDX_W = 13;
   localparam int AW    = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             alloc_valid;
   logic [AW-1:0]    alloc_addr;
   logic [IDX_W-1:0] alloc_index;
   logic             alloc_ready;
   logic             mem_req;
   logic [AW-1:0]    mem_addr;
   logic             mem_gnt;
   logic             mem_rvalid;
   logic             retire_valid;
   logic [IDX_W-1:0] retire_index;
   logic [2:0]       occupancy;

   always #5 clk = ~clk;

   mem_request_scheduler #(
      .TRACKER_SLOTS(SLOTS), .TRACE_ENTRIES(8192), .DATA_ADDR_WIDTH(AW)
   ) dut (
      .clk(clk), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_index(alloc_index),
      .alloc_ready(alloc_ready),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .retire_valid(retire_valid), .retire_index(retire_index), .occupancy(occupancy)
   );

   typedef struct {
      logic [AW-1:0]    addr;
      logic [IDX_W-1:0] idx;
   } exp_t;

   typedef enum int {M_MAKE, M_WAIT, M_RETIRE} mstate_e;

   int      n_checks = 0;
   int      n_pass   = 0;
   exp_t    exp_q[$];
   mstate_e m_state  = M_MAKE;
   int      m_occ    = 0;
   bit      model_on = 1'b0;
   bit      auto_mem = 1'b0;
   bit      rv_pending = 1'b0;
   bit      last_alloc_fire = 1'b0;
   int      ret_seen = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // One clock cycle: drive the optional memory responder, compare the DUT
   // against the model, advance across the rising edge, then update the model.
   task automatic tick();
      bit      a_fire;
      bit      r_fire;
      mstate_e nxt;
      exp_t    e;
      if (auto_mem) begin
         mem_gnt    = mem_req;
         mem_rvalid = rv_pending;
      end
      if (retire_valid === 1'b1) ret_seen++;
      a_fire = 1'b0;
      r_fire = 1'b0;
      nxt    = m_state;
      if (model_on) begin
         check("alloc_ready", alloc_ready, (m_occ != SLOTS));
         check("occupancy", occupancy, m_occ);
         check("mem_req", mem_req, (m_state == M_MAKE && m_occ > 0));
         if (m_state == M_MAKE && m_occ > 0) check("mem_addr", mem_addr, exp_q[0].addr);
         check("retire_valid", retire_valid, (m_state == M_RETIRE));
         if (m_state == M_RETIRE) check("retire_index", retire_index, exp_q[0].idx);
         a_fire = alloc_valid && (m_occ != SLOTS);
         case (m_state)
            M_MAKE:   if (m_occ > 0 && mem_gnt) nxt = M_WAIT;
            M_WAIT:   if (mem_rvalid) nxt = M_RETIRE;
            M_RETIRE: begin r_fire = 1'b1; nxt = M_MAKE; end
            default:  nxt = M_MAKE;
         endcase
      end
      @(posedge clk);
      #1;
      rv_pending = auto_mem && mem_gnt;
      if (rst) begin
         model_on = 1'b1;
         m_state  = M_MAKE;
         m_occ    = 0;
         exp_q.delete();
         last_alloc_fire = 1'b0;
      end else begin
         last_alloc_fire = a_fire;
         if (r_fire) void'(exp_q.pop_front());
         if (a_fire) begin
            e.addr = alloc_addr;
            e.idx  = alloc_index;
            exp_q.push_back(e);
         end
         m_occ   = m_occ + int'(a_fire) - int'(r_fire);
         m_state = nxt;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int ret_base;
      rst = 1'b1; alloc_valid = 1'b0; alloc_addr = '0; alloc_index = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      #1;
      tick(); tick();
      rst = 1'b0;
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_retire_index", retire_index, 32'h0);

      // Single request: alloc at cycle 0, gnt cycle 2, rvalid cycle 4, retire cycle 5.
      alloc_valid = 1'b1; alloc_addr = 32'h1000; alloc_index = 13'd5;
      tick();
      alloc_valid = 1'b0;
      tick();
      mem_gnt = 1'b1;    tick();
      mem_gnt = 1'b0;    tick();
      mem_rvalid = 1'b1; tick();
      mem_rvalid = 1'b0; tick();
      tick();

      // Fill the tracker with no grants, then offer a fifth request.
      for (int i = 0; i < SLOTS; i++) begin
         alloc_valid = 1'b1; alloc_addr = 32'h2000 + 32'(i * 4); alloc_index = IDX_W'(20 + i);
         tick();
      end
      alloc_addr = 32'hDEAD; alloc_index = 13'd99;
      repeat (3) tick();
      check("fill_occ", occupancy, SLOTS);

      // Keep the fifth request offered while the head retires.
      auto_mem = 1'b1;
      alloc_addr = 32'h3000; alloc_index = 13'd30;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (last_alloc_fire) break;
      end
      alloc_valid = 1'b0;
      check("full_reaccept_occ", occupancy, SLOTS);
      for (int i = 0; i < 100 && occupancy != 0; i++) tick();
      check("drain1_occ", occupancy, 0);

      // Six requests through a four-entry ring with back-to-back memory.
      n = 0;
      ret_base = ret_seen;
      for (int i = 0; i < 80; i++) begin
         alloc_valid = (n < 6);
         alloc_addr  = 32'h4000 + 32'(n * 16);
         alloc_index = IDX_W'(10 + n);
         tick();
         if (last_alloc_fire) n++;
         if (n == 6 && occupancy == 0 && retire_valid == 1'b0) break;
      end
      alloc_valid = 1'b0;
      tick();
      check("wrap_drained", occupancy, 0);
      check("wrap_retire_count", ret_seen - ret_base, 6);

      // Stray rvalid while idle and while a request waits for grant.
      auto_mem = 1'b0; mem_gnt = 1'b0;
      mem_rvalid = 1'b1; tick();
      mem_rvalid = 1'b0; tick();
      alloc_valid = 1'b1; alloc_addr = 32'h5000; alloc_index = 13'd7;
      tick();
      alloc_valid = 1'b0;
      mem_rvalid = 1'b1; tick();
      mem_rvalid = 1'b0;
      mem_gnt = 1'b1;    tick();
      mem_gnt = 1'b0;    tick();

      // Reset while waiting for the memory response.
      rst = 1'b1; tick();
      rst = 1'b0;
      check("rst2_mem_req", mem_req, 1'b0);
      check("rst2_retire_valid", retire_valid, 1'b0);
      check("rst2_mem_addr", mem_addr, 32'h0);
      check("rst2_retire_index", retire_index, 32'h0);
      check("rst2_occ", occupancy, 0);
      check("rst2_ready", alloc_ready, 1'b1);
      mem_rvalid = 1'b1; tick();
      mem_rvalid = 1'b0; tick();
      check("rst2_no_retire", retire_valid, 1'b0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_request_scheduler.md
MEM_REQUEST_SCHEDULER -- requirements
Module: mem_request_scheduler

Interface
REQ-001 The block SHALL have parameter TRACKER_SLOTS, default 4 (power of two, 2..16), the number of outstanding trace memory requests held.
REQ-002 The block SHALL have parameter TRACE_ENTRIES, default 8192, the trace repository depth; IDX_W = $clog2(TRACE_ENTRIES).
REQ-003 The block SHALL have parameter DATA_ADDR_WIDTH, default 32, the data address width.
REQ-004 The block SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port alloc_valid  input  1  a new trace memory request is offered.
REQ-007 The block SHALL have port alloc_addr  input  DATA_ADDR_WIDTH  the memory address of the offered request.
REQ-008 The block SHALL have port alloc_index  input  IDX_W  the trace repository index of the offered request.
REQ-009 The block SHALL have port alloc_ready  output  1  a free tracker slot exists.
REQ-010 The block SHALL have port mem_req  output  1  request to the memory port.
REQ-011 The block SHALL have port mem_addr  output  DATA_ADDR_WIDTH  the address of the request being issued.
REQ-012 The block SHALL have port mem_gnt  input  1  memory accepted the request.
REQ-013 The block SHALL have port mem_rvalid  input  1  memory completed the granted request.
REQ-014 The block SHALL have port retire_valid  output  1  one-cycle pulse: a request retired.
REQ-015 The block SHALL have port retire_index  output  IDX_W  the trace index of the retired request.
REQ-016 The block SHALL have port occupancy  output  $clog2(TRACKER_SLOTS+1)  count of occupied slots.

Function
REQ-017 The block SHALL hold TRACKER_SLOTS entries of type cache_tracker_t {occupied, mem_addr, processing, trace_index} in a ring with head (issue) and tail (allocate) pointers of $clog2(TRACKER_SLOTS) bits that wrap modulo TRACKER_SLOTS.
REQ-018 An allocation SHALL occur when alloc_valid && alloc_ready: slot[tail] <= {1, alloc_addr, 0, alloc_index}, tail++.
REQ-019 alloc_ready SHALL be (occupancy != TRACKER_SLOTS), computed from registered state only; a retire in the same cycle SHALL NOT raise alloc_ready when full.
REQ-020 The issue FSM SHALL have states MAKE_REQUEST, WAIT_FOR_PROCESSING and REQUEST_RETIRED (mem_action encoding).
REQ-021 In MAKE_REQUEST, mem_req SHALL equal slot[head].occupied, and mem_addr SHALL equal slot[head].mem_addr; otherwise mem_req = 0.
REQ-022 mem_req and mem_addr SHALL remain stable until mem_gnt; on mem_req && mem_gnt, slot[head].processing <= 1 and the FSM SHALL move to WAIT_FOR_PROCESSING.
REQ-023 In WAIT_FOR_PROCESSING, mem_rvalid SHALL move the FSM to REQUEST_RETIRED; mem_rvalid in any other state SHALL be ignored.
REQ-024 REQUEST_RETIRED SHALL last exactly one cycle, in which: retire_valid = 1; retire_index = slot[head].trace_index; slot[head].occupied and .processing are cleared at the cycle end; head++; next state is MAKE_REQUEST.
REQ-025 Latency: an allocation at edge t into an empty tracker SHALL give mem_req = 1 in the cycle after edge t; minimum per-request period SHALL be 3 cycles (gnt, rvalid, retire).
REQ-026 Retirement order SHALL equal allocation order.
REQ-027 occupancy SHALL be +1 on allocate only, -1 on retire only, and unchanged on simultaneous allocate and retire.
REQ-028 An allocation into the tail slot SHALL never overwrite an occupied slot; tail == head with occupancy 0 means empty, and with occupancy TRACKER_SLOTS means full.
REQ-029 Only one request SHALL be processing at any time.

Reset
REQ-030 While rst = 1 at a clock edge, all slots SHALL be cleared, head = tail = 0, occupancy = 0, FSM = MAKE_REQUEST; mem_req = 0, retire_valid = 0, mem_addr = 0, retire_index = 0, and alloc_ready = 1 from the following cycle.
REQ-031 Reset asserted mid-transaction SHALL drop the in-flight request without a retire pulse; a later mem_rvalid SHALL be ignored.

Verification
REQ-032 Single request: alloc (0x1000, idx 5); gnt at cycle 2; rvalid at cycle 4 -> mem_req at cycle 1 with mem_addr 0x1000; retire_valid at cycle 5 with retire_index 5; occupancy 1 -> 0.
REQ-033 Fill: 4 allocations with no gnt (SLOTS = 4) -> alloc_ready = 0 and occupancy = 4; a 5th alloc_valid is not accepted; slot contents are unchanged.
REQ-034 Full plus retire: tracker full, with an alloc held during the retire cycle -> accepted one cycle after the retire; occupancy goes 4, 3, 4.
REQ-035 Order and wrap: 6 requests idx 10..15 with back-to-back gnt/rvalid -> retire_index sequence 10..15; head and tail wrap past 3; occupancy never exceeds 4.
REQ-036 Stray or reset: rvalid in MAKE_REQUEST is ignored (no retire); rst asserted during WAIT_FOR_PROCESSING -> outputs are zero next cycle, and the following rvalid produces no retire_valid.
